// File: rtl/pwm_pattern_engine.sv
// pwm_pattern_engine
//   N-channel LED PWM pattern engine. A per-channel duty pattern is stepped
//   on a prescaled tick enable. The step can hold, rotate up, rotate down or
//   bounce. Every duty is scaled by a global brightness. New duties reach the
//   outputs only at PWM period boundaries, so the outputs never glitch.
//
//   Ports:
//     clk         system clock, the only clock
//     reset       synchronous, active-high reset
//     enable      1 = prescaler runs, 0 = prescaler frozen (no steps)
//     mode        00 hold, 01 rotate up, 10 rotate down, 11 bounce
//     brightness  global scale factor; all-ones leaves duties unchanged
//     pwm_out     registered PWM outputs, bit i = channel i
//     step_pulse  one-cycle pulse in the cycle the pattern has just stepped
//     head_pos    index of the channel that holds the full-duty head
module pwm_pattern_engine #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned TICK_DIV  = 10_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [PWM_WIDTH-1:0]      brightness,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      step_pulse,
  output logic [$clog2(NUM_CH)-1:0] head_pos
);

  localparam int unsigned W     = PWM_WIDTH;
  localparam int unsigned HW    = $clog2(NUM_CH);
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PRODW = 2 * W + 1;
  localparam int unsigned PATW  = NUM_CH * W;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  DUTY_MAX   = '1;
  localparam logic [W-1:0]  CNT_LAST   = DUTY_MAX - W'(1);
  localparam logic [HW-1:0] HEAD_LAST  = HW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  // Comet shape: full duty on channel 0, halving toward higher channels.
  function automatic logic [PATW-1:0] init_pattern();
    logic [PATW-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (k < W) begin
        p[k*W +: W] = DUTY_MAX >> k;
      end
    end
    return p;
  endfunction

  localparam logic [PATW-1:0] PATTERN_RESET = init_pattern();

  // Channel i occupies bits [i*W +: W] of each flattened duty vector.
  logic [PATW-1:0]   pattern_q, pattern_d;
  logic [PATW-1:0]   eff_q, eff_d;
  logic [PATW-1:0]   active_q, active_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  dir_e              dir_q, dir_d;
  logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
  logic              step_pulse_q, step_pulse_d;
  logic [HW-1:0]     head_q, head_d;

  mode_e mode_sel;
  logic  tick;
  logic  boundary;
  logic  rot_up;
  logic  rot_dn;
  logic [W:0] bright_p1;

  assign mode_sel  = mode_e'(mode);
  assign tick      = enable && (presc_q == PRESC_LAST);
  assign boundary  = (cnt_q == CNT_LAST);
  assign bright_p1 = {1'b0, brightness} + (W+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q    <= PATTERN_RESET;
      eff_q        <= '0;
      active_q     <= '0;
      cnt_q        <= '0;
      presc_q      <= '0;
      dir_q        <= DIR_UP;
      pwm_out_q    <= '0;
      step_pulse_q <= 1'b0;
      head_q       <= '0;
    end else begin
      pattern_q    <= pattern_d;
      eff_q        <= eff_d;
      active_q     <= active_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      dir_q        <= dir_d;
      pwm_out_q    <= pwm_out_d;
      step_pulse_q <= step_pulse_d;
      head_q       <= head_d;
    end
  end

  // Bounce direction: flips only when a bounce step meets an end channel.
  always_comb begin
    dir_d = dir_q;
    if (tick && (mode_sel == MODE_BOUNCE)) begin
      if ((dir_q == DIR_UP) && (head_q == HEAD_LAST)) begin
        dir_d = DIR_DOWN;
      end else if ((dir_q == DIR_DOWN) && (head_q == '0)) begin
        dir_d = DIR_UP;
      end
    end
  end

  // Rotation for this tick. In bounce mode the end-of-travel turnaround
  // already rotates in the new direction during the same tick.
  always_comb begin
    rot_up = 1'b0;
    rot_dn = 1'b0;
    if (tick) begin
      case (mode_sel)
        MODE_HOLD:   ;
        MODE_UP:     rot_up = 1'b1;
        MODE_DOWN:   rot_dn = 1'b1;
        MODE_BOUNCE: begin
          if ((dir_q == DIR_UP) && (head_q == HEAD_LAST)) begin
            rot_dn = 1'b1;
          end else if ((dir_q == DIR_DOWN) && (head_q == '0)) begin
            rot_up = 1'b1;
          end else if (dir_q == DIR_UP) begin
            rot_up = 1'b1;
          end else begin
            rot_dn = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pattern_d    = pattern_q;
    head_d       = head_q;
    presc_d      = presc_q;
    cnt_d        = boundary ? '0 : cnt_q + W'(1);
    step_pulse_d = tick;

    if (enable) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end

    if (rot_up) begin
      pattern_d = {pattern_q[PATW-W-1:0], pattern_q[PATW-1 -: W]};
      head_d    = (head_q == HEAD_LAST) ? '0 : head_q + HW'(1);
    end else if (rot_dn) begin
      pattern_d = {pattern_q[W-1:0], pattern_q[PATW-1:W]};
      head_d    = (head_q == '0) ? HEAD_LAST : head_q - HW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PRODW-1:0] prod;

    // (2^W-1)*2^W >> W still fits in W bits, so the truncation is lossless.
    assign prod                = PRODW'(pattern_q[i*W +: W]) * PRODW'(bright_p1);
    assign eff_d[i*W +: W]     = W'(prod >> W);
    assign active_d[i*W +: W]  = boundary ? eff_q[i*W +: W] : active_q[i*W +: W];
    assign pwm_out_d[i]        = (cnt_q < active_q[i*W +: W]);
  end

  assign pwm_out    = pwm_out_q;
  assign step_pulse = step_pulse_q;
  assign head_pos   = head_q;

endmodule

// File: tb/tb_pwm_pattern_engine.sv
// tb_pwm_pattern_engine
//   Directed bench for pwm_pattern_engine with NUM_CH=4, PWM_WIDTH=4,
//   TICK_DIV=5. Inputs change and outputs are sampled on the falling edge.
//   Duties are measured by counting high cycles over one full 15-cycle period.
module tb_pwm_pattern_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] brightness = 4'd15;
  logic [3:0] pwm_out;
  logic       step_pulse;
  logic [1:0] head_pos;

  int checks = 0;
  int failures = 0;
  int hi [4];

  pwm_pattern_engine #(
    .NUM_CH(4),
    .PWM_WIDTH(4),
    .TICK_DIV(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .brightness(brightness),
    .pwm_out(pwm_out),
    .step_pulse(step_pulse),
    .head_pos(head_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Duties must be stable before calling: 17 cycles always reach a fresh
  // period with the current duties loaded, then one full period is counted.
  task automatic measure();
    repeat (17) cyc();
    for (int c = 0; c < 4; c++) hi[c] = 0;
    repeat (15) begin
      cyc();
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm_out[c]);
    end
  endtask

  task automatic chk_duty(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_ch0"}, hi[0], e0);
    chk({tag, "_ch1"}, hi[1], e1);
    chk({tag, "_ch2"}, hi[2], e2);
    chk({tag, "_ch3"}, hi[3], e3);
  endtask

  // Returns on the falling edge of the cycle where the n-th pulse is seen.
  task automatic wait_steps(input string tag, input int n);
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    while ((seen < n) && (budget < 200)) begin
      cyc();
      budget++;
      if (step_pulse) seen++;
    end
    chk({tag, "_steps_seen"}, seen, n);
  endtask

  initial begin
    int steps;
    int toggles;
    logic [3:0] prev;

    // 1: hold mode, full brightness
    mode = 2'b00;
    enable = 1'b1;
    brightness = 4'd15;
    do_reset();
    chk("rst_pwm_out", pwm_out, 0);
    chk("rst_step_pulse", step_pulse, 0);
    chk("rst_head_pos", head_pos, 0);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      chk($sformatf("t1_step_c%0d", c), step_pulse, (c % 5) == 0);
      if (c == 15) chk("t1_first_period_low", pwm_out, 0);
      if (c == 16) chk("t1_period2_start", pwm_out, 4'b1111);
      if (c >= 16) begin
        for (int k = 0; k < 4; k++) hi[k] += int'(pwm_out[k]);
      end
    end
    chk_duty("t1_duty", 15, 7, 3, 1);
    chk("t1_head", head_pos, 0);

    // 2: rotate up
    mode = 2'b01;
    do_reset();
    wait_steps("t2a", 1);
    chk("t2_head_1", head_pos, 1);
    enable = 1'b0;
    measure();
    chk_duty("t2_duty_1", 1, 15, 7, 3);
    enable = 1'b1;
    wait_steps("t2b", 3);
    chk("t2_head_4", head_pos, 0);
    enable = 1'b0;
    measure();
    chk_duty("t2_duty_4", 15, 7, 3, 1);
    enable = 1'b1;

    // 3: rotate down
    mode = 2'b10;
    do_reset();
    wait_steps("t3", 1);
    chk("t3_head", head_pos, 3);
    enable = 1'b0;
    measure();
    chk_duty("t3_duty", 7, 3, 1, 15);
    enable = 1'b1;

    // 4: bounce
    mode = 2'b11;
    do_reset();
    wait_steps("t4_1", 1); chk("t4_head_1", head_pos, 1);
    wait_steps("t4_2", 1); chk("t4_head_2", head_pos, 2);
    wait_steps("t4_3", 1); chk("t4_head_3", head_pos, 3);
    wait_steps("t4_4", 1); chk("t4_head_4", head_pos, 2);
    wait_steps("t4_5", 1); chk("t4_head_5", head_pos, 1);
    wait_steps("t4_6", 1); chk("t4_head_6", head_pos, 0);
    wait_steps("t4_7", 1); chk("t4_head_7", head_pos, 1);

    // 5: brightness scaling
    mode = 2'b00;
    brightness = 4'd7;
    do_reset();
    measure();
    chk_duty("t5_b7", 7, 3, 1, 0);
    brightness = 4'd0;
    measure();
    chk_duty("t5_b0", 0, 0, 0, 0);
    brightness = 4'd15;

    // 6: prescaler freeze, then reset mid-period
    mode = 2'b01;
    do_reset();
    wait_steps("t6", 1);
    enable = 1'b0;
    steps = 0;
    toggles = 0;
    prev = pwm_out;
    repeat (20) begin
      cyc();
      if (step_pulse) steps++;
      if (pwm_out != prev) toggles++;
      prev = pwm_out;
    end
    chk("t6_frozen_no_steps", steps, 0);
    chk("t6_frozen_head", head_pos, 1);
    chk("t6_pwm_running", toggles > 0, 1);
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("t6_resume_step_%0d", k), step_pulse, k == 5);
    end
    chk("t6_head_after_resume", head_pos, 2);
    chk("t6_pwm_nonzero", pwm_out != 4'b0000, 1);
    reset = 1'b1;
    cyc();
    chk("t6_rst_pwm_out", pwm_out, 0);
    chk("t6_rst_head", head_pos, 0);
    chk("t6_rst_step", step_pulse, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
